// File: rtl/apb_cfg_regs_if.sv
// APB bus bundle for apb_cfg_regs: the requester drives the master modport,
// the register file sits on the slave modport.
interface apb_cfg_regs_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    localparam int unsigned StrbWidth = (DataWidth + 7) / 8;

    logic [AddrWidth-1:0] paddr;
    logic [2:0]           pprot;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [DataWidth-1:0] pwdata;
    logic [StrbWidth-1:0] pstrb;
    logic                 pready;
    logic [DataWidth-1:0] prdata;
    logic                 pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_cfg_regs.sv
// APB configuration register file with read-only masking, hardware write-back,
// write-notify pulses and wait states. Define APB_CFG_REGS_LOCK_EN to add the lock_i write lock.
module apb_cfg_regs #(
    parameter int unsigned        NoRegs     = 4,
    parameter int unsigned        AddrWidth  = 32,
    parameter int unsigned        DataWidth  = 32,
    parameter int unsigned        WaitCycles = 0,
    parameter logic [NoRegs-1:0]  RoMask     = '0
) (
    input  logic                        pclk_i,
    input  logic                        preset_ni,
`ifdef APB_CFG_REGS_LOCK_EN
    input  logic                        lock_i,
`endif
    apb_cfg_regs_if.slave               apb,
    input  logic [NoRegs*DataWidth-1:0] init_i,
    input  logic [NoRegs-1:0]           hw_we_i,
    input  logic [NoRegs*DataWidth-1:0] hw_d_i,
    output logic [NoRegs*DataWidth-1:0] q_o,
    output logic [NoRegs-1:0]           wr_pulse_o
);
    localparam int unsigned StrbWidth = (DataWidth + 7) / 8;
    localparam int unsigned OffW      = $clog2(StrbWidth);
    localparam int unsigned IdxW      = AddrWidth - OffW;
    localparam int unsigned CmpW      = (IdxW > 32) ? IdxW + 1 : 33;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e                        state_q, state_d;
    logic [3:0]                    cnt_q, cnt_d;
    logic [NoRegs*DataWidth-1:0]   regs_q, regs_d;
    logic [NoRegs-1:0]             wr_pulse_q, wr_pulse_d;

    logic                          access_s;
    logic                          done_s;
    logic [IdxW-1:0]               idx_s;
    logic                          in_range_s;
    logic [NoRegs-1:0]             hit_s;
    logic                          ro_s;
    logic [DataWidth-1:0]          sel_data_s;
    logic                          lock_s;
    logic                          commit_s;
    logic                          pslverr_s;
    logic [DataWidth-1:0]          prdata_s;
    logic [DataWidth-1:0]          wmask_s;
    logic                          unused_s;

    // Strobe bit s covers data bits 8s..8s+7; the top strobe may cover a partial byte.
    function automatic logic [DataWidth-1:0] strb_to_mask(input logic [StrbWidth-1:0] strb);
        logic [DataWidth-1:0] m;
        m = '0;
        for (int i = 0; i < int'(DataWidth); i++) begin
            m[i] = strb[i / 8];
        end
        return m;
    endfunction

`ifdef APB_CFG_REGS_LOCK_EN
    assign lock_s = lock_i;
`else
    assign lock_s = 1'b0;
`endif

    assign unused_s = ^{apb.pprot, apb.paddr};
    assign access_s = apb.psel & apb.penable;

    // Completion detect: zero-wait completes in the first access cycle without leaving IDLE.
    always_comb begin
        if (WaitCycles == 0) begin
            done_s = access_s;
        end else begin
            done_s = access_s && (state_q == ACCESS) && (cnt_q == 4'(WaitCycles));
        end
    end

    // Address decode; the range check uses the truncated word index.
    always_comb begin
        idx_s      = apb.paddr[AddrWidth-1:OffW];
        in_range_s = (CmpW'(idx_s) < CmpW'(NoRegs));
        hit_s      = '0;
        ro_s       = 1'b0;
        sel_data_s = '0;
        for (int r = 0; r < int'(NoRegs); r++) begin
            if (CmpW'(idx_s) == CmpW'(r)) begin
                hit_s[r]   = 1'b1;
                ro_s       = RoMask[r];
                sel_data_s = regs_q[r*DataWidth +: DataWidth];
            end else begin
                hit_s[r]   = 1'b0;
            end
        end
    end

    // Response and commit decision, only on the completion cycle.
    always_comb begin
        pslverr_s = 1'b0;
        prdata_s  = '0;
        commit_s  = 1'b0;
        if (done_s) begin
            if (!in_range_s) begin
                pslverr_s = 1'b1;
            end else if (apb.pwrite) begin
                if (ro_s || lock_s) begin
                    pslverr_s = 1'b1;
                end else begin
                    commit_s  = 1'b1;
                end
            end else begin
                prdata_s = sel_data_s;
            end
        end else begin
            pslverr_s = 1'b0;
        end
    end

    // Register next state: an APB commit owns the whole word, dropping any hw update to it.
    always_comb begin
        wmask_s    = strb_to_mask(apb.pstrb);
        regs_d     = regs_q;
        wr_pulse_d = '0;
        for (int r = 0; r < int'(NoRegs); r++) begin
            if (commit_s && hit_s[r]) begin
                regs_d[r*DataWidth +: DataWidth] = (regs_q[r*DataWidth +: DataWidth] & ~wmask_s)
                                                 | (apb.pwdata & wmask_s);
                wr_pulse_d[r] = |apb.pstrb;
            end else if (hw_we_i[r]) begin
                regs_d[r*DataWidth +: DataWidth] = hw_d_i[r*DataWidth +: DataWidth];
            end else begin
                regs_d[r*DataWidth +: DataWidth] = regs_q[r*DataWidth +: DataWidth];
            end
        end
    end

    // Access-phase FSM next state; any drop of psel/penable aborts back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (access_s && (WaitCycles != 0)) begin
                    state_d = ACCESS;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
            ACCESS: begin
                if (!access_s || done_s) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ACCESS;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM state and wait counter.
    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Register storage and notify pulses; reset tracks init_i while held.
    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            regs_q     <= init_i;
            wr_pulse_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign apb.pready  = done_s;
    assign apb.pslverr = pslverr_s;
    assign apb.prdata  = prdata_s;
    assign q_o         = regs_q;
    assign wr_pulse_o  = wr_pulse_q;
endmodule

// File: tb/tb_apb_cfg_regs.sv
// Directed bench for apb_cfg_regs: zero-wait/RO instance (A), 3-wait instance (B), 2-wait reset instance (C).
module tb_apb_cfg_regs;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_c_n;
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [127:0] INIT_A = {32'h33333333, 32'h00000000, 32'h00000000, 32'h11110000};
    localparam logic [127:0] INIT_B = {32'h00000000, 32'h00000000, 32'hCAFE0001, 32'h12345678};
    localparam logic [127:0] INIT_C = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};

    logic [127:0] q_a, q_b, q_c, hw_d_a, hw_d_b, hw_d_c;
    logic [3:0]   pulse_a, pulse_b, pulse_c, hw_we_a, hw_we_b, hw_we_c;
`ifdef APB_CFG_REGS_LOCK_EN
    logic lock_a, lock_b, lock_c;
`endif

    apb_cfg_regs_if #(.AddrWidth(32), .DataWidth(32)) ifa ();
    apb_cfg_regs_if #(.AddrWidth(32), .DataWidth(32)) ifb ();
    apb_cfg_regs_if #(.AddrWidth(32), .DataWidth(32)) ifc ();

    apb_cfg_regs #(.NoRegs(4), .AddrWidth(32), .DataWidth(32), .WaitCycles(0), .RoMask(4'b1000)) dut_a (
        .pclk_i(clk), .preset_ni(rst_n),
`ifdef APB_CFG_REGS_LOCK_EN
        .lock_i(lock_a),
`endif
        .apb(ifa), .init_i(INIT_A), .hw_we_i(hw_we_a), .hw_d_i(hw_d_a), .q_o(q_a), .wr_pulse_o(pulse_a));

    apb_cfg_regs #(.NoRegs(4), .AddrWidth(32), .DataWidth(32), .WaitCycles(3), .RoMask(4'b0000)) dut_b (
        .pclk_i(clk), .preset_ni(rst_n),
`ifdef APB_CFG_REGS_LOCK_EN
        .lock_i(lock_b),
`endif
        .apb(ifb), .init_i(INIT_B), .hw_we_i(hw_we_b), .hw_d_i(hw_d_b), .q_o(q_b), .wr_pulse_o(pulse_b));

    apb_cfg_regs #(.NoRegs(4), .AddrWidth(32), .DataWidth(32), .WaitCycles(2), .RoMask(4'b0000)) dut_c (
        .pclk_i(clk), .preset_ni(rst_c_n),
`ifdef APB_CFG_REGS_LOCK_EN
        .lock_i(lock_c),
`endif
        .apb(ifc), .init_i(INIT_C), .hw_we_i(hw_we_c), .hw_d_i(hw_d_c), .q_o(q_c), .wr_pulse_o(pulse_c));

    logic        rdy, err, early;
    logic [31:0] rd, cyc;

    function automatic logic [31:0] w(input logic [127:0] q, input int r);
        return q[r*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Zero-wait transfer on instance A; samples the response in the access cycle.
    task automatic apb_a(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb);
        @(negedge clk);
        ifa.psel = 1'b1; ifa.penable = 1'b0; ifa.pwrite = wr;
        ifa.paddr = addr; ifa.pwdata = wdata; ifa.pstrb = strb;
        @(negedge clk);
        ifa.penable = 1'b1;
        #1;
        rdy = ifa.pready; err = ifa.pslverr; rd = ifa.prdata;
        @(negedge clk);
        ifa.psel = 1'b0; ifa.penable = 1'b0;
        #1;
    endtask

    // Waited transfer on instance B; cyc is the access cycle carrying pready (0 on timeout).
    task automatic apb_b(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb);
        logic [127:0] qs;
        qs = q_b; cyc = 32'd0; early = 1'b0; err = 1'bx; rd = 32'hx;
        @(negedge clk);
        ifb.psel = 1'b1; ifb.penable = 1'b0; ifb.pwrite = wr;
        ifb.paddr = addr; ifb.pwdata = wdata; ifb.pstrb = strb;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            ifb.penable = 1'b1;
            #1;
            if (ifb.pready === 1'b1) begin
                cyc = 32'(k); err = ifb.pslverr; rd = ifb.prdata;
                break;
            end else if (q_b !== qs) begin
                early = 1'b1;
            end
        end
        @(negedge clk);
        ifb.psel = 1'b0; ifb.penable = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rst_c_n = 1'b0;
        ifa.psel = 1'b0; ifa.penable = 1'b0; ifa.pwrite = 1'b0; ifa.paddr = 32'h0;
        ifa.pwdata = 32'h0; ifa.pstrb = 4'h0; ifa.pprot = 3'b000;
        ifb.psel = 1'b0; ifb.penable = 1'b0; ifb.pwrite = 1'b0; ifb.paddr = 32'h0;
        ifb.pwdata = 32'h0; ifb.pstrb = 4'h0; ifb.pprot = 3'b000;
        ifc.psel = 1'b0; ifc.penable = 1'b0; ifc.pwrite = 1'b0; ifc.paddr = 32'h0;
        ifc.pwdata = 32'h0; ifc.pstrb = 4'h0; ifc.pprot = 3'b000;
        hw_we_a = 4'h0; hw_we_b = 4'h0; hw_we_c = 4'h0;
        hw_d_a = 128'h0; hw_d_b = 128'h0; hw_d_c = 128'h0;
`ifdef APB_CFG_REGS_LOCK_EN
        lock_a = 1'b0; lock_b = 1'b0; lock_c = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        for (int r = 0; r < 4; r++) chk($sformatf("rst_a_q%0d", r), w(q_a, r), w(INIT_A, r));
        chk("rst_a_pready", 32'(ifa.pready), 32'd0);
        chk("rst_a_pslverr", 32'(ifa.pslverr), 32'd0);
        chk("rst_a_prdata", ifa.prdata, 32'h0);
        chk("rst_a_pulse", 32'(pulse_a), 32'd0);
        rst_n = 1'b1; rst_c_n = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_b_q0", w(q_b, 0), 32'h12345678);

        // T1: zero-wait write then read
        apb_a(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
        chk("t1_wr_rdy", 32'(rdy), 32'd1);
        chk("t1_wr_err", 32'(err), 32'd0);
        chk("t1_q1", w(q_a, 1), 32'hDEADBEEF);
        chk("t1_pulse", 32'(pulse_a), 32'h2);
        @(negedge clk); #1;
        chk("t1_pulse_gone", 32'(pulse_a), 32'h0);
        apb_a(1'b0, 32'h4, 32'h0, 4'h0);
        chk("t1_rd_rdy", 32'(rdy), 32'd1);
        chk("t1_rd_err", 32'(err), 32'd0);
        chk("t1_rd_data", rd, 32'hDEADBEEF);
        apb_a(1'b0, 32'h7, 32'h0, 4'h0);
        chk("unaligned_rd", rd, 32'hDEADBEEF);

        // T3: byte strobes, then empty strobe
        apb_a(1'b1, 32'h8, 32'hFFFFFFFF, 4'b0101);
        chk("t3_q2", w(q_a, 2), 32'h00FF00FF);
        chk("t3_pulse", 32'(pulse_a), 32'h4);
        apb_a(1'b1, 32'h8, 32'h12345678, 4'b0000);
        chk("t3_strb0_err", 32'(err), 32'd0);
        chk("t3_strb0_q2", w(q_a, 2), 32'h00FF00FF);
        chk("t3_strb0_pulse", 32'(pulse_a), 32'h0);
        apb_a(1'b1, 32'h0, 32'hAABBCCDD, 4'b1000);
        chk("top_byte_q0", w(q_a, 0), 32'hAA110000);

        // T4: read-only register and out-of-range index
        apb_a(1'b1, 32'hC, 32'h12345678, 4'hF);
        chk("t4_ro_err", 32'(err), 32'd1);
        chk("t4_ro_q3", w(q_a, 3), 32'h33333333);
        chk("t4_ro_pulse", 32'(pulse_a), 32'h0);
        apb_a(1'b0, 32'hC, 32'h0, 4'h0);
        chk("t4_ro_rd_err", 32'(err), 32'd0);
        chk("t4_ro_rd", rd, 32'h33333333);
        apb_a(1'b0, 32'h10, 32'h0, 4'h0);
        chk("t4_oor_err", 32'(err), 32'd1);
        chk("t4_oor_data", rd, 32'h0);

        // T5: APB commit collides with hw write to reg 0
        @(negedge clk);
        ifa.psel = 1'b1; ifa.penable = 1'b0; ifa.pwrite = 1'b1;
        ifa.paddr = 32'h0; ifa.pwdata = 32'h5A; ifa.pstrb = 4'hF;
        @(negedge clk);
        ifa.penable = 1'b1; hw_we_a = 4'b0001; hw_d_a = {96'h0, 32'hA5};
        #1 chk("t5_coll_rdy", 32'(ifa.pready), 32'd1);
        @(negedge clk);
        ifa.psel = 1'b0; ifa.penable = 1'b0; hw_we_a = 4'h0;
        #1;
        chk("t5_coll_q0", w(q_a, 0), 32'h0000005A);
        chk("t5_coll_pulse", 32'(pulse_a), 32'h1);
        @(negedge clk);
        hw_we_a = 4'b1001; hw_d_a = {32'hCAFEF00D, 64'h0, 32'hA5};
        @(negedge clk);
        hw_we_a = 4'h0;
        #1;
        chk("t5_hw_q0", w(q_a, 0), 32'h000000A5);
        chk("t5_hw_ro_q3", w(q_a, 3), 32'hCAFEF00D);
        chk("t5_hw_pulse", 32'(pulse_a), 32'h0);
        @(negedge clk);
        ifa.psel = 1'b1; ifa.penable = 1'b0; ifa.pwrite = 1'b1;
        ifa.paddr = 32'h0; ifa.pwdata = 32'h000000EE; ifa.pstrb = 4'b0001;
        @(negedge clk);
        ifa.penable = 1'b1; hw_we_a = 4'b0001; hw_d_a = {96'h0, 32'hFFFFFFFF};
        @(negedge clk);
        ifa.psel = 1'b0; ifa.penable = 1'b0; hw_we_a = 4'h0;
        #1 chk("t5_partial_coll_q0", w(q_a, 0), 32'h000000EE);

`ifdef APB_CFG_REGS_LOCK_EN
        lock_a = 1'b1;
        apb_a(1'b1, 32'h4, 32'h0, 4'hF);
        chk("lock_wr_err", 32'(err), 32'd1);
        chk("lock_q1", w(q_a, 1), 32'hDEADBEEF);
        chk("lock_pulse", 32'(pulse_a), 32'h0);
        apb_a(1'b0, 32'h4, 32'h0, 4'h0);
        chk("lock_rd_err", 32'(err), 32'd0);
        chk("lock_rd", rd, 32'hDEADBEEF);
        lock_a = 1'b0;
`endif

        // T2: three wait states on instance B
        apb_b(1'b0, 32'h0, 32'h0, 4'h0);
        chk("t2_rd_cyc", cyc, 32'd4);
        chk("t2_rd_data", rd, 32'h12345678);
        chk("t2_rd_err", 32'(err), 32'd0);
        apb_b(1'b1, 32'h4, 32'h0BADF00D, 4'hF);
        chk("t2_wr_cyc", cyc, 32'd4);
        chk("t2_wr_early", 32'(early), 32'd0);
        chk("t2_wr_q1", w(q_b, 1), 32'h0BADF00D);
        chk("t2_wr_pulse", 32'(pulse_b), 32'h2);
        // Aborted transfer: penable drops after two access cycles
        @(negedge clk);
        ifb.psel = 1'b1; ifb.penable = 1'b0; ifb.pwrite = 1'b1;
        ifb.paddr = 32'h8; ifb.pwdata = 32'hFFFFFFFF; ifb.pstrb = 4'hF;
        @(negedge clk); ifb.penable = 1'b1;
        @(negedge clk);
        @(negedge clk); ifb.psel = 1'b0; ifb.penable = 1'b0;
        #1 chk("abort_pready", 32'(ifb.pready), 32'd0);
        @(negedge clk); #1;
        chk("abort_q2", w(q_b, 2), 32'h0);
        chk("abort_pulse", 32'(pulse_b), 32'h0);
        apb_b(1'b0, 32'h4, 32'h0, 4'h0);
        chk("post_abort_cyc", cyc, 32'd4);
        chk("post_abort_rd", rd, 32'h0BADF00D);
        apb_b(1'b0, 32'h10, 32'h0, 4'h0);
        chk("b_oor_err", 32'(err), 32'd1);
        chk("b_oor_data", rd, 32'h0);

        // T6: reset during the second wait cycle on instance C
        @(negedge clk);
        ifc.psel = 1'b1; ifc.penable = 1'b0; ifc.pwrite = 1'b1;
        ifc.paddr = 32'h0; ifc.pwdata = 32'h99; ifc.pstrb = 4'hF;
        @(negedge clk); ifc.penable = 1'b1;
        #1 chk("t6_wait1_pready", 32'(ifc.pready), 32'd0);
        @(negedge clk); rst_c_n = 1'b0;
        #1;
        chk("t6_rst_pready", 32'(ifc.pready), 32'd0);
        for (int r = 0; r < 4; r++) chk($sformatf("t6_rst_q%0d", r), w(q_c, r), w(INIT_C, r));
        @(negedge clk); ifc.psel = 1'b0; ifc.penable = 1'b0;
        @(negedge clk); rst_c_n = 1'b1;
        @(negedge clk); #1;
        chk("t6_after_q0", w(q_c, 0), 32'hC0C0C0C0);
        chk("t6_after_pulse", 32'(pulse_c), 32'h0);
        @(negedge clk);
        ifc.psel = 1'b1; ifc.penable = 1'b0;
        cyc = 32'd0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            ifc.penable = 1'b1;
            #1;
            if (ifc.pready === 1'b1) begin
                cyc = 32'(k);
                break;
            end
        end
        chk("t6_redo_cyc", cyc, 32'd3);
        @(negedge clk); ifc.psel = 1'b0; ifc.penable = 1'b0;
        #1 chk("t6_redo_q0", w(q_c, 0), 32'h00000099);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
